disp_ram: RTL and testbench
===========================

DISP_RAM -- requirements
Module: disp_ram

Interface
REQ-001 Parameter SCAN_W, default 16: width of the digit-scan prescaler; each digit is lit for 2^SCAN_W clocks.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 startline  input  2  departure line number, 0..3.
REQ-005 startpoint  input  6  departure station index on startline, 0..63.
REQ-006 endline  input  2  destination line number, 0..3.
REQ-007 endpoint  input  6  destination station index on endline, 0..63.
REQ-008 segg  output  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}; dp always off (1).
REQ-009 an  output  8  digit anodes, active-low, one-hot-zero; bit n selects digit n.

Function
REQ-010 The module SHALL register all four inputs every clock; the registered copies are the only source for fare and display.
REQ-011 Stop count SHALL be |endpoint-startpoint| when startline==endline, else startpoint+endpoint (transfer through station 0 of each line); 7-bit unsigned, max 126.
REQ-012 Fare (decimal, 0..6) SHALL come from the stop count: 0 -> 0; 1-4 -> 2; 5-8 -> 3; 9-16 -> 4; 17-32 -> 5; 33+ -> 6.
REQ-013 Fare SHALL be held in a register updated every clock; it reflects a new input value exactly 2 clocks after that value is present at the ports.
REQ-014 Digit map (digit n = an[n]): 7 startline; 6 startpoint tens; 5 startpoint ones; 4 endline; 3 endpoint tens; 2 endpoint ones; 1 fare tens (always 0); 0 fare ones.
REQ-015 Binary-to-decimal for 0..63 SHALL be exact (tens 0..6, ones 0..9); no leading-zero blanking.
REQ-016 Glyphs 0-9 SHALL use standard seven-segment shapes (e.g. 0 -> segg 8'hC0, 1 -> 8'hF9, 2 -> 8'hA4, 3 -> 8'hB0).
REQ-017 A SCAN_W-bit prescaler SHALL free-run; on wrap to 0 the 3-bit digit index SHALL increment, wrapping 7 -> 0.
REQ-018 an and segg SHALL be registered; both update on the same clock, so they never disagree about the digit being shown.
REQ-019 Input changes SHALL NOT reset the scan; the new value appears the next time each digit's slot is driven.

Reset
REQ-020 While rst=1 at a clock edge: prescaler, digit index, input registers and fare SHALL go to 0; an SHALL be 8'hFF and segg SHALL be 8'hFF (all off).
REQ-021 On the first clock after rst falls, an SHALL be 8'hFE (digit 0) and segg SHALL show the fare digit for the registered inputs.
REQ-022 When rst is asserted mid-scan, the scan SHALL restart from digit 0.

Structure
REQ-023 A shared package SHALL hold the seven-segment glyph table, the fare thresholds and fare values, and the digit-index constants.
REQ-024 A single sub-module, seg7_decode (4-bit value in, 8-bit active-low pattern out, combinational), SHALL be used; the rest stays in disp_ram.

Verification
REQ-025 Bench uses SCAN_W=2 and a 20 ns clk.
REQ-026 After reset, apply start 0/0, end 1/1 -> stop count 1, fare 2; digit 0 shows 8'hA4, digit 1 shows 8'hC0, digit 7 shows 8'hC0, digit 4 shows 8'hF9.
REQ-027 Same line, start 2/10, end 2/3 -> 7 stops, fare 3; digits 6,5 show 1,0; digits 3,2 show 0,3.
REQ-028 Cross line, start 3/63, end 0/63 -> 126 stops, fare 6; digits 6,5 show 6,3.
REQ-029 start 1/5, end 1/5 -> fare 0. Fare boundaries: 4 -> 2, 5 -> 3, 16 -> 4, 17 -> 5, 32 -> 5, 33 -> 6.
REQ-030 Check the an sequence FE, FD, ... 7F, FE, with each digit held for 4 clocks. Assert rst mid-scan -> next cycle an=FF and segg=FF; after release the scan restarts at FE. Check the fare latency is exactly 2 clocks.

Source files
------------

// File: rtl/disp_ram_pkg.sv
// Shared constants for the metro fare display: glyph table, fare bands,
// digit slot assignments and small conversion helpers.
package disp_ram_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp held off
  localparam logic [7:0] SEG_GLYPH [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [6:0] FARE_T1 = 7'd4;
  localparam logic [6:0] FARE_T2 = 7'd8;
  localparam logic [6:0] FARE_T3 = 7'd16;
  localparam logic [6:0] FARE_T4 = 7'd32;

  localparam logic [3:0] FARE_V0 = 4'd0;
  localparam logic [3:0] FARE_V1 = 4'd2;
  localparam logic [3:0] FARE_V2 = 4'd3;
  localparam logic [3:0] FARE_V3 = 4'd4;
  localparam logic [3:0] FARE_V4 = 4'd5;
  localparam logic [3:0] FARE_V5 = 4'd6;

  localparam logic [2:0] DIG_FARE_ONES  = 3'd0;
  localparam logic [2:0] DIG_FARE_TENS  = 3'd1;
  localparam logic [2:0] DIG_END_ONES   = 3'd2;
  localparam logic [2:0] DIG_END_TENS   = 3'd3;
  localparam logic [2:0] DIG_END_LINE   = 3'd4;
  localparam logic [2:0] DIG_START_ONES = 3'd5;
  localparam logic [2:0] DIG_START_TENS = 3'd6;
  localparam logic [2:0] DIG_START_LINE = 3'd7;

  function automatic logic [3:0] fare_of(input logic [6:0] stops);
    if (stops == 7'd0)          return FARE_V0;
    else if (stops <= FARE_T1)  return FARE_V1;
    else if (stops <= FARE_T2)  return FARE_V2;
    else if (stops <= FARE_T3)  return FARE_V3;
    else if (stops <= FARE_T4)  return FARE_V4;
    else                        return FARE_V5;
  endfunction

  // Returns {tens, ones} for a station index 0..63
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/disp_ram_seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern; values
// above 9 blank the digit.
module seg7_decode
  import disp_ram_pkg::*;
(
  input  logic [3:0] val,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (val < 4'd10) seg = SEG_GLYPH[val];
  end

endmodule

// File: rtl/disp_ram.sv
// Metro ticket display: registers the journey inputs, derives the fare from
// the stop count and multiplexes eight seven-segment digits.
module disp_ram
  import disp_ram_pkg::*;
#(
  parameter int SCAN_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] startline,
  input  logic [5:0] startpoint,
  input  logic [1:0] endline,
  input  logic [5:0] endpoint,
  output logic [7:0] segg,
  output logic [7:0] an
);

  logic [1:0]        sl_q, el_q;
  logic [5:0]        sp_q, ep_q;
  logic [3:0]        fare_q;
  logic [SCAN_W-1:0] presc_q;
  logic [2:0]        idx_q;

  logic [6:0] stops;
  logic [7:0] sp_bcd, ep_bcd;
  logic [3:0] digit_val;
  logic [7:0] glyph;

  // Cross-line trips transfer through station 0 of each line
  always_comb begin
    if (sl_q == el_q)
      stops = (sp_q >= ep_q) ? {1'b0, sp_q - ep_q} : {1'b0, ep_q - sp_q};
    else
      stops = {1'b0, sp_q} + {1'b0, ep_q};
  end

  assign sp_bcd = to_bcd(sp_q);
  assign ep_bcd = to_bcd(ep_q);

  always_comb begin
    digit_val = 4'd0;
    case (idx_q)
      DIG_FARE_ONES:  digit_val = fare_q;
      DIG_FARE_TENS:  digit_val = 4'd0;
      DIG_END_ONES:   digit_val = ep_bcd[3:0];
      DIG_END_TENS:   digit_val = ep_bcd[7:4];
      DIG_END_LINE:   digit_val = {2'b00, el_q};
      DIG_START_ONES: digit_val = sp_bcd[3:0];
      DIG_START_TENS: digit_val = sp_bcd[7:4];
      DIG_START_LINE: digit_val = {2'b00, sl_q};
      default:        digit_val = 4'd0;
    endcase
  end

  seg7_decode u_dec (
    .val (digit_val),
    .seg (glyph)
  );

  // an and segg come from the same idx_q sample so they always agree
  always_ff @(posedge clk) begin
    if (rst) begin
      sl_q    <= '0;
      sp_q    <= '0;
      el_q    <= '0;
      ep_q    <= '0;
      fare_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an      <= 8'hFF;
      segg    <= SEG_OFF;
    end else begin
      sl_q    <= startline;
      sp_q    <= startpoint;
      el_q    <= endline;
      ep_q    <= endpoint;
      fare_q  <= fare_of(stops);
      presc_q <= presc_q + 1'b1;
      if (presc_q == '1) idx_q <= idx_q + 3'd1;
      an      <= ~(8'b1 << idx_q);
      segg    <= glyph;
    end
  end

endmodule

// File: tb/tb_disp_ram.sv
// Self-checking bench for disp_ram: scan order, digit contents, fare bands,
// fare latency and mid-scan reset.
module tb_disp_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] startline, endline;
  logic [5:0] startpoint, endpoint;
  logic [7:0] segg, an;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;
  exp_t sb[$];

  always #10 clk = ~clk;

  disp_ram #(.SCAN_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .startline  (startline),
    .startpoint (startpoint),
    .endline    (endline),
    .endpoint   (endpoint),
    .segg       (segg),
    .an         (an)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int fare_m(input int sl, input int sp, input int el, input int ep);
    int s;
    s = (sl == el) ? ((sp > ep) ? sp - ep : ep - sp) : sp + ep;
    if (s == 0) return 0;
    if (s < 5)  return 2;
    if (s < 9)  return 3;
    if (s < 17) return 4;
    if (s < 33) return 5;
    return 6;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_and_push(input string tag, input int sl, input int sp,
                                input int el, input int ep);
    int dv[8];
    exp_t e;
    startline  = 2'(sl);
    startpoint = 6'(sp);
    endline    = 2'(el);
    endpoint   = 6'(ep);
    dv[0] = fare_m(sl, sp, el, ep);
    dv[1] = 0;
    dv[2] = ep % 10;
    dv[3] = ep / 10;
    dv[4] = el;
    dv[5] = sp % 10;
    dv[6] = sp / 10;
    dv[7] = sl;
    for (int d = 0; d < 8; d++) begin
      e.tag = $sformatf("%s_d%0d", tag, d);
      e.an  = ~(8'(1) << d);
      e.seg = glyph(dv[d]);
      sb.push_back(e);
    end
  endtask

  // Returns once the first sample of a digit-0 slot is visible
  task automatic wait_slot0(output bit ok);
    logic [7:0] prev;
    ok   = 1'b0;
    prev = an;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (an == 8'hFE && prev != 8'hFE) begin
        ok = 1'b1;
        return;
      end
      prev = an;
    end
  endtask

  task automatic drain_scan();
    bit   ok;
    exp_t e;
    repeat (3) tick();
    wait_slot0(ok);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout: got an=%h, required digit-0 slot", an);
      sb.delete();
      return;
    end
    for (int d = 0; d < 8; d++) begin
      e = sb.pop_front();
      check_eq({e.tag, "_an"}, an, e.an);
      check_eq({e.tag, "_seg"}, segg, e.seg);
      repeat (4) tick();
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    startline = '0; startpoint = '0; endline = '0; endpoint = '0;
    repeat (2) tick();
    check_eq("rst_an", an, 8'hFF);
    check_eq("rst_seg", segg, 8'hFF);

    rst = 1'b0;
    tick();
    check_eq("rel_seg", segg, glyph(0));
    for (int k = 0; k <= 32; k++) begin
      check_eq($sformatf("an_seq_%0d", k), an, ~(8'(1) << ((k / 4) % 8)));
      tick();
    end

    apply_and_push("v_cross1", 0, 0, 1, 1);   drain_scan();
    apply_and_push("v_same7", 2, 10, 2, 3);   drain_scan();
    apply_and_push("v_max", 3, 63, 0, 63);    drain_scan();
    apply_and_push("v_zero", 1, 5, 1, 5);     drain_scan();
    apply_and_push("b4", 0, 0, 0, 4);         drain_scan();
    apply_and_push("b5", 0, 5, 0, 0);         drain_scan();
    apply_and_push("b16", 1, 20, 1, 4);       drain_scan();
    apply_and_push("b17", 2, 0, 3, 17);       drain_scan();
    apply_and_push("b32", 0, 0, 0, 32);       drain_scan();
    apply_and_push("b33", 0, 33, 0, 0);       drain_scan();

    // Fare latency: fare 6 -> fare 0 while digit 0 stays selected
    wait_slot0(ok);
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL lat_timeout: got an=%h, required digit-0 slot", an);
    end
    startline = 2'd0; startpoint = 6'd0; endline = 2'd0; endpoint = 6'd0;
    tick();
    check_eq("lat_c1", segg, glyph(6));
    tick();
    check_eq("lat_c2", segg, glyph(6));
    tick();
    check_eq("lat_c3", segg, glyph(0));
    check_eq("lat_an", an, 8'hFE);

    // Reset in the middle of digit 3
    wait_slot0(ok);
    repeat (12) tick();
    check_eq("mid_an_pre", an, 8'hF7);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_an", an, 8'hFF);
    check_eq("mid_rst_seg", segg, 8'hFF);
    rst = 1'b0;
    tick();
    check_eq("mid_rel_seg", segg, glyph(0));
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("mid_an_%0d", k), an, (k < 4) ? 8'hFE : 8'hFD);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
